// File: rtl/multicycle_ctrl.sv
// Main control FSM for a multi-cycle MIPS-style datapath: sequences fetch, decode,
// execute, memory and write-back steps and counts retired instructions.
module multicycle_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  instr_op_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        ir_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        reg_write_o,
  output logic        reg_dst_o,
  output logic        mem_to_reg_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  pc_src_o,
  output logic [2:0]  alu_op_o,
  output logic [3:0]  state_o,
  output logic        illegal_o,
  output logic [15:0] instr_cnt_o
);

  localparam int unsigned OP_W    = 6;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned STATE_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(0);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(35);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(43);

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [2:0] ALUOP_FUNCT = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_ADD   = 3'b010;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EX     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;
  logic               retire;

  // Next-state, retire and datapath control decode
  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRCB_REG;
    pc_src_o     = PCSRC_ALU;
    alu_op_o     = ALUOP_FUNCT;
    illegal_o    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        alu_op_o    = ALUOP_ADD;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b_o = SRCB_IMM_SH;
        alu_op_o    = ALUOP_ADD;
        case (instr_op_i)
          OP_RTYPE:     state_d = S_R_EX;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal_o = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = ALUOP_ADD;
        state_d     = (instr_op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read_o = 1'b1;
        if (mem_ready_i) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write_o = 1'b1;
        if (mem_ready_i) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_R_EX: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_REG;
        alu_op_o    = ALUOP_FUNCT;
        state_d     = S_R_WB;
      end
      S_R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_REG;
        alu_op_o    = ALUOP_SUB;
        pc_src_o    = PCSRC_ALUOUT;
        pc_write_o  = zero_i;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_ADDI_EX: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = ALUOP_ADD;
        state_d     = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write_o = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_src_o   = PCSRC_JUMP;
        pc_write_o = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Strobes must be quiet during reset even though the state register reads FETCH
    if (rst_i) begin
      pc_write_o  = 1'b0;
      ir_write_o  = 1'b0;
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      reg_write_o = 1'b0;
      illegal_o   = 1'b0;
    end

    instr_cnt_d = retire ? instr_cnt_q + CNT_W'(1) : instr_cnt_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_FETCH;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign state_o     = STATE_W'(state_q);
  assign instr_cnt_o = instr_cnt_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port instr_op_i, input, 6 bits: opcode field from the instruction register.
REQ-004 SHALL have port zero_i, input, 1 bit: ALU zero flag.
REQ-005 SHALL have port mem_ready_i, input, 1 bit: memory completion strobe for the current read or write.
REQ-006 SHALL have ports pc_write_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o, out, 1 bit each: datapath strobes.
REQ-007 SHALL have ports reg_dst_o, mem_to_reg_o, alu_src_a_o, out, 1 bit each: mux selects.
REQ-008 SHALL have port alu_src_b_o, out, 2 bits: 00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-009 SHALL have port pc_src_o, out, 2 bits: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-010 SHALL have port alu_op_o, out, 3 bits: 000 R-type (funct decode), 001 subtract (branch), 010 add.
REQ-011 SHALL have port state_o, out, 4 bits: current state encoding.
REQ-012 SHALL have port illegal_o, out, 1 bit: one-cycle pulse on an unsupported opcode.
REQ-013 SHALL have port instr_cnt_o, out, 16 bits: count of retired instructions.

Function
REQ-014 SHALL have states FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EX=6, R_WB=7, BRANCH=8, ADDI_EX=9, ADDI_WB=10, JUMP=11; encodings 12-15 SHALL go to FETCH on the next edge.
REQ-015 SHALL in FETCH drive mem_read_o=1, alu_src_a_o=0, alu_src_b_o=01, alu_op_o=010, pc_src_o=00, and drive ir_write_o=pc_write_o=1 only in a cycle where mem_ready_i=1.
REQ-016 SHALL hold FETCH while mem_ready_i=0 (wait states unbounded), then go to DECODE.
REQ-017 SHALL in DECODE drive alu_src_a_o=0, alu_src_b_o=11, alu_op_o=010 (branch target precompute) and dispatch on instr_op_i: 0 to R_EX, 35/43 to MEM_ADDR, 4 to BRANCH, 8 to ADDI_EX, 2 to JUMP, any other to FETCH with illegal_o=1 for that cycle.
REQ-018 SHALL in MEM_ADDR drive alu_src_a_o=1, alu_src_b_o=10, alu_op_o=010, then go to MEM_RD if opcode is 35, otherwise MEM_WR.
REQ-019 SHALL in MEM_RD assert mem_read_o, hold until mem_ready_i=1, then go to MEM_WB; in MEM_WR assert mem_write_o, hold until mem_ready_i=1, then go to FETCH.
REQ-020 SHALL in MEM_WB drive reg_write_o=1, reg_dst_o=0, mem_to_reg_o=1, then go to FETCH.
REQ-021 SHALL in R_EX drive alu_src_a_o=1, alu_src_b_o=00, alu_op_o=000, then go to R_WB; R_WB drives reg_write_o=1, reg_dst_o=1, mem_to_reg_o=0, then FETCH.
REQ-022 SHALL in ADDI_EX drive alu_src_a_o=1, alu_src_b_o=10, alu_op_o=010, then go to ADDI_WB; ADDI_WB drives reg_write_o=1, reg_dst_o=0, mem_to_reg_o=0, then FETCH.
REQ-023 SHALL in BRANCH drive alu_src_a_o=1, alu_src_b_o=00, alu_op_o=001, pc_src_o=01, pc_write_o=zero_i, then go to FETCH.
REQ-024 SHALL in JUMP drive pc_src_o=10, pc_write_o=1, then go to FETCH.
REQ-025 SHALL drive every output not listed for a state to 0.
REQ-026 SHALL increment instr_cnt_o by 1 on each edge leaving MEM_WB, MEM_WR (with mem_ready_i=1), R_WB, ADDI_WB, BRANCH or JUMP; 16'hFFFF SHALL wrap to 0; illegal opcodes SHALL NOT count.
REQ-027 SHALL ignore mem_ready_i in all states other than FETCH, MEM_RD and MEM_WR.
REQ-028 SHALL give instruction latency, with zero wait states, of lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles, plus one cycle per wait cycle.

Reset
REQ-029 SHALL, while rst_i=1, force state to FETCH, instr_cnt_o to 0, and all strobe outputs (pc_write_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o, illegal_o) to 0, regardless of clk_i.
REQ-030 SHALL, when rst_i is asserted mid-instruction, including during a memory wait, abandon that instruction without counting it and restart in FETCH on the first edge after release.

Verification
REQ-031 SHALL pass: reset, then opcode 0 with mem_ready_i=1 -> states 0,1,6,7,0; reg_write_o=1 only in state 7; instr_cnt_o=1.
REQ-032 SHALL pass: lw (35) with 2 wait cycles in MEM_RD -> MEM_RD held 3 cycles; mem_to_reg_o=1 in MEM_WB; total 7 cycles.
REQ-033 SHALL pass: beq (4) with zero_i=0 -> pc_write_o=0 in BRANCH; with zero_i=1 -> pc_write_o=1, pc_src_o=01.
REQ-034 SHALL pass: opcode 63 -> illegal_o=1 for one cycle in DECODE; next state FETCH; instr_cnt_o unchanged.
REQ-035 SHALL pass: preload instr_cnt_o to 16'hFFFF via 65535 j instructions, retire one more -> instr_cnt_o=0.
REQ-036 SHALL pass: rst_i pulsed during a sw wait in MEM_WR -> mem_write_o drops immediately, state=0, instr_cnt_o=0.
